// File: rtl/tau_pkg.sv
// Shared types and helpers for the tau-encoded serial dot-product sequencer.
// Provides the scheduler state enum and the accumulator width function.
package tau_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } tau_sched_state_t;

    // Wide enough for (2^len_w-1)*(2^bitwidth-1)^2 without overflow.
    function automatic int acc_width(input int bitwidth, input int len_w);
        return 2 * bitwidth + len_w;
    endfunction

endpackage

// File: rtl/tau_msb_pick.sv
// Combinational priority picker: index and one-hot mask of the highest set bit.
// Ports: a (input word), idx (bit index), onehot (mask, all-zero when a == 0).
module tau_msb_pick #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  a,
    output logic [IW-1:0] idx,
    output logic [W-1:0]  onehot
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        idx    = '0;
        onehot = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) begin
                idx = IW'(i);
            end
        end
        onehot[idx] = |a;
    end

endmodule

// File: rtl/tau_dot_sched.sv
// Serial multiply-accumulate sequencer: one shifted add of b per set bit of a.
// Ports: job/op/res valid-ready handshakes, abort, busy, clk, async reset.
module tau_dot_sched
    import tau_pkg::*;
#(
    parameter int  BITWIDTH = 8,
    parameter int  LEN_W    = 4,
    localparam int ACC_W    = acc_width(BITWIDTH, LEN_W)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [LEN_W-1:0]    job_len,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [BITWIDTH-1:0] op_a,
    input  logic [BITWIDTH-1:0] op_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACC_W-1:0]    res_data,
    input  logic                abort,
    output logic                busy
);

    localparam int IW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

    tau_sched_state_t state_q, state_d;

    logic [BITWIDTH-1:0] a_q, b_q;
    logic [LEN_W-1:0]    remaining;
    logic [ACC_W-1:0]    acc;

    logic [IW-1:0]       pick_idx;
    logic [BITWIDTH-1:0] pick_mask;
    logic [BITWIDTH-1:0] a_left;
    logic [LEN_W-1:0]    rem_dec;

    tau_msb_pick #(
        .W  (BITWIDTH),
        .IW (IW)
    ) u_pick (
        .a      (a_q),
        .idx    (pick_idx),
        .onehot (pick_mask)
    );

    assign a_left  = a_q & ~pick_mask;
    assign rem_dec = remaining - LEN_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (job_valid) begin
                        state_d = (job_len == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (op_valid) begin
                        if (op_a != '0) begin
                            state_d = SHIFT;
                        end else if (rem_dec != '0) begin
                            state_d = LOAD;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (a_left == '0) begin
                        state_d = (remaining != '0) ? LOAD : DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        job_ready = (state_q == IDLE);
        op_ready  = (state_q == LOAD);
        res_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        res_data  = acc;
    end

    // Abort in IDLE leaves acc alone so an idle abort is truly a no-op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            remaining <= '0;
            acc       <= '0;
        end else if (abort) begin
            if (state_q != IDLE) begin
                acc <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (job_valid) begin
                        acc       <= '0;
                        remaining <= job_len;
                    end
                end
                LOAD: begin
                    if (op_valid) begin
                        a_q       <= op_a;
                        b_q       <= op_b;
                        remaining <= rem_dec;
                    end
                end
                SHIFT: begin
                    acc <= acc + (ACC_W'(b_q) << pick_idx);
                    a_q <= a_left;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tau_dot_sched.sv
// Directed bench for tau_dot_sched with a result scoreboard.
// Drives jobs, stalls, aborts and a mid-job reset; checks data and latency.
module tb_tau_dot_sched;

    logic        clk;
    logic        reset;
    logic        job_valid;
    logic        job_ready;
    logic [3:0]  job_len;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        res_valid;
    logic        res_ready;
    logic [19:0] res_data;
    logic        abort;
    logic        busy;

    logic [7:0]  ja [16];
    logic [7:0]  jb [16];
    logic [19:0] sb_q [$];
    int          checks;
    int          errors;

    tau_dot_sched #(
        .BITWIDTH (8),
        .LEN_W    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_len   (job_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .abort     (abort),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_job_ready"}, 32'(job_ready), 32'd1);
        chk({tag, "_op_ready"},  32'(op_ready),  32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_data"},  32'(res_data),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Runs a job from ja/jb; op_stall inserts one op_valid=0 cycle before
    // every pair after the first, res_hold keeps res_ready low that long.
    task automatic run_job(input string tag, input int n, input bit op_stall,
                           input int res_hold, input bit abort_done);
        int          exp_lat;
        int          cyc;
        int          idx;
        int          hs;
        bit          stalled;
        logic [19:0] sum;
        logic [19:0] exp;
        sum     = '0;
        exp_lat = 1;
        for (int i = 0; i < n; i++) begin
            sum     = sum + 20'(ja[i]) * 20'(jb[i]);
            exp_lat = exp_lat + 1 + $countones(ja[i]);
        end
        if (op_stall && n > 1) exp_lat = exp_lat + n - 1;
        sb_q.push_back(sum);

        chk({tag, "_job_ready"}, 32'(job_ready), 32'd1);
        job_valid = 1'b1;
        job_len   = 4'(n);
        tick;
        job_valid = 1'b0;
        cyc     = 1;
        idx     = 0;
        stalled = 1'b0;
        while (!res_valid && cyc < 400) begin
            hs = 0;
            op_valid = 1'b0;
            if (op_ready && idx < n) begin
                if (op_stall && idx > 0 && !stalled) begin
                    stalled = 1'b1;
                end else begin
                    op_valid = 1'b1;
                    op_a     = ja[idx];
                    op_b     = jb[idx];
                    hs       = 1;
                    stalled  = 1'b0;
                end
            end
            tick;
            op_valid = 1'b0;
            idx = idx + hs;
            cyc++;
        end
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_latency"},   32'(cyc),       32'(exp_lat));

        if (abort_done) begin
            res_ready = 1'b1;
            abort     = 1'b1;
            tick;
            res_ready = 1'b0;
            abort     = 1'b0;
            void'(sb_q.pop_front());
            chk_idle_outputs({tag, "_abort_done"});
            return;
        end

        for (int i = 0; i < res_hold; i++) begin
            job_valid = 1'b1;
            job_len   = 4'd1;
            tick;
            chk({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
            chk({tag, "_hold_data"},  32'(res_data),  32'(sb_q[0]));
            chk({tag, "_hold_jrdy"},  32'(job_ready), 32'd0);
        end
        job_valid = 1'b0;

        exp = sb_q.pop_front();
        res_ready = 1'b1;
        chk({tag, "_res_data"}, 32'(res_data), 32'(exp));
        tick;
        res_ready = 1'b0;
        chk({tag, "_after_jrdy"}, 32'(job_ready), 32'd1);
        chk({tag, "_after_rv"},   32'(res_valid), 32'd0);
        chk({tag, "_after_busy"}, 32'(busy),      32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        job_valid = 1'b0;
        job_len   = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;
        abort     = 1'b0;
        tick;
        tick;
        chk_idle_outputs("reset");
        reset = 1'b0;
        tick;

        ja[0] = 8'h0B; jb[0] = 8'd3;
        run_job("single", 1, 1'b0, 0, 1'b0);

        ja[0] = 8'd2;  jb[0] = 8'd5;
        ja[1] = 8'd0;  jb[1] = 8'd9;
        ja[2] = 8'hFF; jb[2] = 8'd1;
        run_job("vector", 3, 1'b0, 0, 1'b0);

        run_job("empty", 0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            ja[i] = 8'hFF;
            jb[i] = 8'hFF;
        end
        run_job("max", 15, 1'b0, 0, 1'b0);

        ja[0] = 8'd2;  jb[0] = 8'd5;
        ja[1] = 8'd0;  jb[1] = 8'd9;
        ja[2] = 8'hFF; jb[2] = 8'd1;
        run_job("bp", 3, 1'b1, 4, 1'b0);

        // Abort while pair 2 of 3 is in SHIFT.
        ja[0] = 8'd3; jb[0] = 8'd1;
        ja[1] = 8'd5; jb[1] = 8'd2;
        ja[2] = 8'd7; jb[2] = 8'd3;
        job_valid = 1'b1;
        job_len   = 4'd3;
        tick;
        job_valid = 1'b0;
        op_valid  = 1'b1;
        op_a      = ja[0];
        op_b      = jb[0];
        tick;
        op_valid = 1'b0;
        tick;
        tick;
        chk("abort_in_load", 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        op_a     = ja[1];
        op_b     = jb[1];
        tick;
        op_valid = 1'b0;
        chk("abort_in_shift_ordy", 32'(op_ready), 32'd0);
        chk("abort_in_shift_busy", 32'(busy),     32'd1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk_idle_outputs("abort_shift");
        run_job("after_abort", 3, 1'b0, 0, 1'b0);

        ja[0] = 8'd6; jb[0] = 8'd7;
        run_job("abdone", 1, 1'b0, 0, 1'b1);
        ja[0] = 8'h81; jb[0] = 8'd200;
        run_job("after_abdone", 1, 1'b0, 0, 1'b0);

        // Asynchronous reset while in SHIFT.
        ja[0] = 8'hFF; jb[0] = 8'd1;
        job_valid = 1'b1;
        job_len   = 4'd1;
        tick;
        job_valid = 1'b0;
        op_valid  = 1'b1;
        op_a      = ja[0];
        op_b      = jb[0];
        tick;
        op_valid = 1'b0;
        tick;
        chk("rst_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk_idle_outputs("rst_mid");
        tick;
        reset = 1'b0;
        tick;
        ja[0] = 8'hFF; jb[0] = 8'd2;
        run_job("post_reset", 1, 1'b0, 0, 1'b0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tau_dot_sched.md
# tau_dot_sched

Sequencer for the tau-encoded serial multiply-accumulate datapath. It accepts a dot-product job of `len` operand pairs and pulls each pair `(a, b)` over a valid/ready handshake. It forms each product serially by adding one shifted copy of `b` per set bit of `a`, highest bit first, and returns the accumulated sum over a result handshake. The block has its own clearable accumulator, so consecutive jobs need no external reset.

## Interface
- `BITWIDTH`, 8: operand width for `a` and `b`.
- `LEN_W`, 4: job-length width; a job has at most 2^LEN_W-1 pairs.
- `ACC_W`, 2*BITWIDTH+LEN_W (derived, not overridable): accumulator and result width.
- `clk`  in  1  the single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `job_valid`  in  1  a new job request is present.
- `job_ready`  out  1  the block can accept a job; high only in IDLE.
- `job_len`  in  LEN_W  number of operand pairs; sampled on the job handshake.
- `op_valid`  in  1  an operand pair is present.
- `op_ready`  out  1  the block can accept a pair; high only in LOAD.
- `op_a`  in  BITWIDTH  multiplier, consumed one set bit at a time.
- `op_b`  in  BITWIDTH  multiplicand, kept in binary.
- `res_valid`  out  1  the result is valid; high only in DONE.
- `res_ready`  in  1  the consumer accepts the result.
- `res_data`  out  ACC_W  accumulated dot product.
- `abort`  in  1  synchronous cancel of the current job.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- The state machine has four states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - `job_ready`=1.
  - On `job_valid`: the accumulator clears to 0 and `remaining` is set to `job_len`.
  - If `job_len`=0 the next state is DONE. Otherwise it is LOAD.
- LOAD:
  - `op_ready`=1.
  - On `op_valid`: `a_q`<=`op_a`, `b_q`<=`op_b`, and `remaining` decrements.
  - If `op_a`≠0 the next state is SHIFT.
  - If `op_a`=0 there is no add. The next state is LOAD if `remaining` after the decrement is non-zero, otherwise DONE.
- SHIFT (one cycle per set bit):
  - k = index of the highest set bit of `a_q`.
  - acc <= acc + (zero-extended `b_q` << k), and bit k of `a_q` is cleared.
  - When the cleared `a_q` becomes 0, the next state is LOAD if `remaining`≠0, otherwise DONE.
- DONE:
  - `res_valid`=1 and `res_data`=acc, both held stable until `res_ready`.
  - On the handshake the next state is IDLE.
- Arithmetic is unsigned.
  - The largest possible sum is (2^LEN_W-1)·(2^BITWIDTH-1)², which is less than 2^ACC_W, so the accumulator never overflows.
  - There is no wrap or saturation logic.
- `abort`:
  - In any state, the next state is IDLE and the accumulator clears.
  - An operand or result handshake in the same cycle as `abort` is void: the pair is discarded, and the result counts as not transferred.
  - `abort` in IDLE has no effect, and any `job_valid` in that cycle is ignored.
- While reset is asserted the outputs are: `job_ready`=1 (state IDLE), `op_ready`=0, `res_valid`=0, `res_data`=0, `busy`=0. All registers, including `a_q`, `b_q`, `remaining` and acc, are 0.
- A reset asserted mid-job discards the job without reporting it.

## Timing
- All ready and valid outputs decode directly from the registered state. There is no combinational path from any input to any output.
- Cycles per pair = 1 (LOAD accept) + popcount(a). A pair with a=0 costs 1 cycle.
- Job latency, from the job handshake to `res_valid`: 1 + Σ(1+popcount(a_i)) cycles, plus any cycles where `op_valid` is low in LOAD.
- For `job_len`=0, `res_valid` rises the cycle after the job handshake.
- `job_ready` rises the cycle after the result handshake. Jobs can therefore run back to back with one IDLE cycle between them.
- `op_ready` stays low throughout SHIFT and DONE.

## Structure
- Package `tau_pkg`:
  - state enum `tau_sched_state_t` (IDLE, LOAD, SHIFT, DONE);
  - function `acc_width(BITWIDTH, LEN_W)`.
- Sub-module `tau_msb_pick`: a combinational priority picker that returns the highest-set-bit index k and a one-hot mask of `a_q`, BITWIDTH-generic. It is instanced once, and the shift-add is done in the parent.

## Test plan
- **Single pair:** `job_len`=1, a=0x0B, b=3.
  - Three SHIFT cycles add 24, 6, 3.
  - `res_data`=33.
  - `res_valid` 5 cycles after the job handshake.
- **Vector:** `job_len`=3, pairs (2,5), (0,9), (0xFF,1).
  - `res_data`=10+0+255=265.
  - The a=0 pair takes exactly 1 cycle.
- **Empty and maximum jobs:**
  - `job_len`=0 gives `res_data`=0 with `res_valid` on the next cycle.
  - `job_len`=15 with every a=b=0xFF gives `res_data`=975375 and no overflow.
- **Backpressure:**
  - With `op_valid` toggling 1-0-1, stalls occur only in LOAD.
  - With `res_ready` held low for 4 cycles, `res_valid` and `res_data` stay stable, and the next job is accepted only after the handshake.
- **Abort:**
  - `abort` during SHIFT of pair 2 of 3 returns to IDLE the next cycle with acc=0; the next job then computes correctly.
  - `abort` together with `res_ready` in DONE produces no transfer.
- **Reset mid-job:** assert `reset` asynchronously in SHIFT. The outputs go immediately to their reset values, and the first job after release gives the correct result.
